multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Moore-style control FSM that sequences a shared-ALU, shared-memory multicycle RV32I datapath.
//  Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.
//  Every cycle it drives the mux selects, write enables and ALU operation; it waits on a memory ready handshake.
//  Also keeps a retired-instruction counter. Sits beside the datapath in place of the single-cycle control unit.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter instret
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high; clears FSM and counter
//  op         in   7      instruction opcode (from IR)
//  f3         in   3      funct3
//  f7         in   1      funct7 bit 5
//  zero       in   1      ALU zero flag
//  mem_ready  in   1      memory completes the current access this cycle
//  pcWrite    out  1      PC register load
//  adrSrc     out  1      memory address: 0=PC, 1=ALUOut
//  memWrite   out  1      memory write strobe
//  irWrite    out  1      IR/oldPC load
//  resSrc     out  2      result mux: 00=ALUOut, 01=memData, 10=ALUResult
//  aluSrcA    out  2      00=PC, 01=oldPC, 10=rs1
//  aluSrcB    out  2      00=rs2, 01=imm, 10=const 4
//  immSrc     out  2      00=I, 01=S, 10=B, 11=J; combinational from op, state-independent
//  ALUcontrol out  3      000 add, 001 sub, 010 and, 011 or, 101 slt
//  regWrite   out  1      register file write
//  illegal    out  1      1-cycle pulse in DECODE for an unsupported opcode
//  instret    out  CNT_W  count of retired instructions
// BEHAVIOUR
//  State register and instret use async reset; all outputs are combinational from state (+ inputs noted).
//  While reset=1: state=FETCH, instret=0, and pcWrite/irWrite/memWrite/regWrite/illegal are forced to 0.
//  Unlisted outputs default to 0 in every state.
//  FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=add, resSrc=10.
//    irWrite=pcWrite=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
//  DECODE: aluSrcA=01, aluSrcB=01, aluOp=add (precomputes branch target). Next state by op:
//    0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BEQ; 1101111 -> JAL;
//    any other opcode -> illegal=1, go to FETCH, no retire.
//  MEMADR: aluSrcA=10, aluSrcB=01, add. op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE.
//  MEMREAD: adrSrc=1, resSrc=00. Hold until mem_ready, then -> MEMWB.
//  MEMWB: resSrc=01, regWrite=1 -> FETCH.
//  MEMWRITE: adrSrc=1, resSrc=00, memWrite=1. memWrite stays high until the mem_ready cycle, then -> FETCH.
//  EXEC_R: aluSrcA=10, aluSrcB=00, funct decode -> ALUWB.
//  EXEC_I: aluSrcA=10, aluSrcB=01, funct decode -> ALUWB.
//  ALUWB: resSrc=00, regWrite=1 -> FETCH.
//  JAL: aluSrcA=01, aluSrcB=10, add, resSrc=00, pcWrite=1 -> ALUWB (rd=PC+4).
//  BEQ: aluSrcA=10, aluSrcB=00, sub, resSrc=00, pcWrite=zero -> FETCH.
//  Funct decode (f3): 000 -> sub if op[5]&f7, else add; 010 slt; 110 or; 111 and; other f3 -> add.
//  instret increments by 1 (wraps at 2^CNT_W) on each exit to FETCH from MEMWB, MEMWRITE, ALUWB, BEQ.
//  Reset asserted mid-instruction aborts immediately: no write enable is asserted after reset rises.
//  Latency with mem_ready always 1: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
//  Each stalled memory cycle adds 1 cycle.
// TESTING
//  add x3,x1,x2 (op 0110011, f3 000, f7 0), mem_ready=1
//    -> FETCH,DECODE,EXEC_R,ALUWB; ALUcontrol=000; regWrite=1 in cycle 4 only; instret 0->1.
//  sub (f7=1) and addi with f7=1 (op 0010011)
//    -> ALUcontrol 001 for sub, 000 for addi.
//  lw with mem_ready low 3 cycles in FETCH and 2 in MEMREAD
//    -> 10 cycles total; irWrite pulses exactly once; regWrite once with resSrc=01.
//  beq, zero=1 then zero=0
//    -> pcWrite=1 in BEQ only when zero=1; ALUcontrol=001; 3 cycles each.
//  sw, mem_ready low 2 cycles in MEMWRITE
//    -> memWrite high 3 consecutive cycles with adrSrc=1; then FETCH.
//  opcode 1111111 -> illegal=1 for 1 cycle, back to FETCH, instret unchanged.
//  Reset asserted in MEMWB -> regWrite=0 immediately; state=FETCH; instret=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath (lw, sw, R/I ALU, beq, jal).
// Outputs are decoded from the current state (plus mem_ready/zero), and retired instructions are counted.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op,
   input  logic [2:0]       f3,
   input  logic             f7,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pcWrite,
   output logic             adrSrc,
   output logic             memWrite,
   output logic             irWrite,
   output logic [1:0]       resSrc,
   output logic [1:0]       aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [1:0]       immSrc,
   output logic [2:0]       ALUcontrol,
   output logic             regWrite,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXEC_R, EXEC_I, ALUWB, JAL, BEQ
   } state_t;

   state_t     state, nxt;
   logic       pc_we, mem_we, ir_we, rf_we, ill, retire;
   logic [2:0] funct_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       instret <= '0;
      else if (retire) instret <= instret + CNT_W'(1);
   end

   // f3/f7 decode shared by EXEC_R and EXEC_I; op[5] keeps addi from becoming sub.
   always_comb begin
      funct_op = ALU_ADD;
      case (f3)
         3'b000:  funct_op = (op[5] & f7) ? ALU_SUB : ALU_ADD;
         3'b010:  funct_op = ALU_SLT;
         3'b110:  funct_op = ALU_OR;
         3'b111:  funct_op = ALU_AND;
         default: funct_op = ALU_ADD;
      endcase
   end

   always_comb begin
      immSrc = 2'b00;
      case (op)
         OP_SW:   immSrc = 2'b01;
         OP_BEQ:  immSrc = 2'b10;
         OP_JAL:  immSrc = 2'b11;
         default: immSrc = 2'b00;
      endcase
   end

   always_comb begin
      nxt        = state;
      pc_we      = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      rf_we      = 1'b0;
      ill        = 1'b0;
      retire     = 1'b0;
      adrSrc     = 1'b0;
      resSrc     = 2'b00;
      aluSrcA    = 2'b00;
      aluSrcB    = 2'b00;
      ALUcontrol = ALU_ADD;
      case (state)
         FETCH: begin
            aluSrcB = 2'b10;
            resSrc  = 2'b10;
            ir_we   = mem_ready;
            pc_we   = mem_ready;
            if (mem_ready) nxt = DECODE;
         end
         DECODE: begin
            aluSrcA = 2'b01;
            aluSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_R:         nxt = EXEC_R;
               OP_I:         nxt = EXEC_I;
               OP_BEQ:       nxt = BEQ;
               OP_JAL:       nxt = JAL;
               default: begin
                  ill = 1'b1;
                  nxt = FETCH;
               end
            endcase
         end
         MEMADR: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b01;
            nxt     = op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adrSrc = 1'b1;
            if (mem_ready) nxt = MEMWB;
         end
         MEMWB: begin
            resSrc = 2'b01;
            rf_we  = 1'b1;
            retire = 1'b1;
            nxt    = FETCH;
         end
         MEMWRITE: begin
            adrSrc = 1'b1;
            mem_we = 1'b1;
            if (mem_ready) begin
               retire = 1'b1;
               nxt    = FETCH;
            end
         end
         EXEC_R: begin
            aluSrcA    = 2'b10;
            ALUcontrol = funct_op;
            nxt        = ALUWB;
         end
         EXEC_I: begin
            aluSrcA    = 2'b10;
            aluSrcB    = 2'b01;
            ALUcontrol = funct_op;
            nxt        = ALUWB;
         end
         ALUWB: begin
            rf_we  = 1'b1;
            retire = 1'b1;
            nxt    = FETCH;
         end
         JAL: begin
            aluSrcA = 2'b01;
            aluSrcB = 2'b10;
            pc_we   = 1'b1;
            nxt     = ALUWB;
         end
         BEQ: begin
            aluSrcA    = 2'b10;
            ALUcontrol = ALU_SUB;
            pc_we      = zero;
            retire     = 1'b1;
            nxt        = FETCH;
         end
         default: nxt = FETCH;
      endcase
   end

   // Strobes are masked by reset so an abort takes effect in the same cycle.
   assign pcWrite  = pc_we  & ~reset;
   assign memWrite = mem_we & ~reset;
   assign irWrite  = ir_we  & ~reset;
   assign regWrite = rf_we  & ~reset;
   assign illegal  = ill    & ~reset;

endmodule
